alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_CYCLES, default 2, number of EXEC cycles spent on a MUL operation (legal range 1-15).
REQ-002 Parameter OTHER_CYCLES, default 1, number of EXEC cycles spent on every non-MUL code (legal range 1-15).
REQ-003 clk_i  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req0_valid_i / req1_valid_i  input  1  requester n has an operation pending.
REQ-006 req0_ready_o / req1_ready_o  output  1  grant pulse; operation n accepted this cycle.
REQ-007 req0_data1_i, req0_data2_i / req1_data1_i, req1_data2_i  input  32  operands of requester n.
REQ-008 req0_ctrl_i / req1_ctrl_i  input  3  ALU code: ADD=000, SUB=001, MUL=010, OR=110, AND=111.
REQ-009 alu_data1_o, alu_data2_o  output  32  registered operands driven to the shared ALU.
REQ-010 alu_ctrl_o  output  3  registered ALU code driven to the shared ALU.
REQ-011 alu_result_i  input  32  combinational ALU result.
REQ-012 resp_valid_o  output  1  result available.
REQ-013 resp_id_o  output  1  index of the requester owning the result.
REQ-014 resp_data_o  output  32  captured result.
REQ-015 resp_ready_i  input  1  consumer accepts the result.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; exactly one operation SHALL be in flight at a time.
REQ-017 IDLE: if any valid, the arbiter SHALL assert the winner's ready for exactly one cycle, latch its operands, code and id into the alu_* and id registers, load the cycle counter, and go to EXEC.
REQ-018 Arbitration SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not granted last.
REQ-019 ready SHALL be asserted only in IDLE, only for the granted requester, and never for both in one cycle.
REQ-020 Counter load SHALL be MUL_CYCLES-1 when the code is 010, else OTHER_CYCLES-1.
REQ-021 EXEC: the counter SHALL decrement each cycle; in the cycle it reads 0, alu_result_i SHALL be captured into resp_data_o and the FSM SHALL go to RESP.
REQ-022 Request-to-resp_valid latency SHALL be 1 + the configured cycle count (defaults: 2 cycles for non-MUL, 3 for MUL, counted from the grant edge).
REQ-023 Codes other than the five listed SHALL be forwarded unchanged; the controller SHALL NOT reject or alter them.
REQ-024 RESP: resp_valid_o SHALL be high and resp_id_o, resp_data_o SHALL be stable until the cycle resp_ready_i is high; on that edge resp_valid_o SHALL drop and the FSM SHALL return to IDLE.
REQ-025 A new grant SHALL NOT occur in the same cycle as the response handshake; the earliest next grant is the following cycle.
REQ-026 alu_data1_o, alu_data2_o, alu_ctrl_o SHALL hold their last granted values outside EXEC.
REQ-027 Requester inputs SHALL be sampled only on the grant cycle; changes at other times SHALL have no effect.
REQ-028 A requester deasserting valid before being granted SHALL lose its turn without error.

Reset
REQ-029 When rst_i is high at a rising edge, state SHALL become IDLE in any state, including mid-EXEC or RESP; the in-flight operation SHALL be discarded with no response.
REQ-030 Reset values: req0_ready_o=0, req1_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_data_o=0, alu_data1_o=0, alu_data2_o=0, alu_ctrl_o=000, counter=0.
REQ-031 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contested arbitration.
REQ-032 No ready SHALL be asserted in a cycle where rst_i is high.

Verification
REQ-033 req0: ADD, data1=5, data2=7; resp_ready_i=1 -> req0_ready_o pulses once, resp_valid_o 2 cycles after grant, resp_id_o=0, resp_data_o=12.
REQ-034 req1: MUL, data1=6, data2=7 (defaults) -> resp_valid_o 3 cycles after grant, resp_id_o=1, resp_data_o=42.
REQ-035 Both valid continuously after reset, req0 SUB 9-4 and req1 OR 0xF0|0x0F -> grant order 0,1,0,1; results 5 (id 0) and 0xFF (id 1) alternate.
REQ-036 resp_ready_i held low 5 cycles after resp_valid_o -> resp_valid_o, resp_id_o, resp_data_o stable; no grant until 1 cycle after the handshake.
REQ-037 rst_i pulsed during MUL EXEC -> no response; all outputs return to reset values; the next contested request grants req0.
REQ-038 Code 011 with data1=0x1234 -> resp_data_o equals alu_result_i (0x1234 from the team ALU's pass-through default).

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU.
// Grants one operation at a time with round-robin priority, drives the registered
// operands to the ALU for a code-dependent number of cycles, captures the result and
// holds it until the consumer accepts it.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES   = 2,
  parameter int unsigned OTHER_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ctrl_i,

  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ctrl_i,

  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,

  output logic        resp_valid_o,
  output logic        resp_id_o,
  output logic [31:0] resp_data_o,
  input  logic        resp_ready_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] CTRL_MUL = 3'b010;

  // Counter counts down to zero, so it is loaded with one less than the cycle count.
  localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] OTHER_LOAD = 4'(OTHER_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_last;
  logic        r_id;
  logic [31:0] r_resp_data;
  logic [31:0] r_alu_data1;
  logic [31:0] r_alu_data2;
  logic [2:0]  r_alu_ctrl;

  logic        w_pick1;
  logic        w_grant_en;
  logic        w_grant0;
  logic        w_grant1;
  logic [31:0] w_sel_data1;
  logic [31:0] w_sel_data2;
  logic [2:0]  w_sel_ctrl;
  logic [3:0]  w_cnt_load;
  logic        w_exec_done;

  // Round-robin pick: requester 1 wins when it is alone, or when both are pending and
  // requester 0 was granted last.
  always_comb begin
    w_pick1    = req1_valid_i & (~req0_valid_i | ~r_last);
    w_grant_en = (r_state == ST_IDLE) & ~rst_i & (req0_valid_i | req1_valid_i);
    w_grant0   = w_grant_en & ~w_pick1;
    w_grant1   = w_grant_en & w_pick1;
  end

  // Operand mux for the winning requester and its cycle budget.
  always_comb begin
    w_sel_data1 = w_pick1 ? req1_data1_i : req0_data1_i;
    w_sel_data2 = w_pick1 ? req1_data2_i : req0_data2_i;
    w_sel_ctrl  = w_pick1 ? req1_ctrl_i  : req0_ctrl_i;
    w_cnt_load  = (w_sel_ctrl == CTRL_MUL) ? MUL_LOAD : OTHER_LOAD;
  end

  assign w_exec_done = (r_state == ST_EXEC) && (r_cnt == 4'd0);

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_en) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_exec_done) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Return to IDLE only; the next grant is evaluated in the following cycle.
        if (resp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winner's operation; ALU registers hold it until the next grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_alu_data1 <= 32'd0;
      r_alu_data2 <= 32'd0;
      r_alu_ctrl  <= 3'b000;
      r_id        <= 1'b0;
    end else if (w_grant_en) begin
      r_alu_data1 <= w_sel_data1;
      r_alu_data2 <= w_sel_data2;
      r_alu_ctrl  <= w_sel_ctrl;
      r_id        <= w_pick1;
    end
  end

  // Last-grant pointer; resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= 1'b1;
    end else if (w_grant_en) begin
      r_last <= w_pick1;
    end
  end

  // Execution cycle counter: loaded on grant, counts down while in EXEC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= 4'd0;
    end else if (w_grant_en) begin
      r_cnt <= w_cnt_load;
    end else if ((r_state == ST_EXEC) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture the ALU result in the last EXEC cycle; held through RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_resp_data <= 32'd0;
    end else if (w_exec_done) begin
      r_resp_data <= alu_result_i;
    end
  end

  assign req0_ready_o = w_grant0;
  assign req1_ready_o = w_grant1;
  assign alu_data1_o  = r_alu_data1;
  assign alu_data2_o  = r_alu_data2;
  assign alu_ctrl_o   = r_alu_ctrl;
  assign resp_valid_o = (r_state == ST_RESP);
  assign resp_id_o    = r_id;
  assign resp_data_o  = r_resp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int MUL_C   = 2;
  localparam int OTHER_C = 1;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_data1, alu_data2;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_ready;

  int checks   = 0;
  int failures = 0;
  int model_last = 1;

  alu_arbiter #(
    .MUL_CYCLES  (MUL_C),
    .OTHER_CYCLES(OTHER_C)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_data1_i(req0_data1),
    .req0_data2_i(req0_data2),
    .req0_ctrl_i (req0_ctrl),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_data1_i(req1_data1),
    .req1_data2_i(req1_data2),
    .req1_ctrl_i (req1_ctrl),
    .alu_data1_o (alu_data1),
    .alu_data2_o (alu_data2),
    .alu_ctrl_o  (alu_ctrl),
    .alu_result_i(alu_result),
    .resp_valid_o(resp_valid),
    .resp_id_o   (resp_id),
    .resp_data_o (resp_data),
    .resp_ready_i(resp_ready)
  );

  // Team ALU behaviour; unknown codes pass data1 through.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a * b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_ref(alu_ctrl, alu_data1, alu_data2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic scramble_inputs();
    req0_data1 = $urandom; req0_data2 = $urandom; req0_ctrl = 3'($urandom);
    req1_data1 = $urandom; req1_data2 = $urandom; req1_ctrl = 3'($urandom);
  endtask

  // One full transaction, entered at posedge+1 with the DUT idle; leaves at posedge+1 idle.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold, input string tag);
    int          exp_id;
    int          exp_lat;
    int          lat;
    logic [2:0]  ec;
    logic [31:0] ea, eb, exp_data;
    logic [1:0]  exp_rdy;
    logic        busy_rdy;
    logic        unstable;

    req0_valid = v0; req0_ctrl = c0; req0_data1 = a0; req0_data2 = b0;
    req1_valid = v1; req1_ctrl = c1; req1_data1 = a1; req1_data2 = b1;
    resp_ready = 1'b0;

    if (v0 && v1) exp_id = 1 - model_last;
    else if (v1)  exp_id = 1;
    else          exp_id = 0;
    ec = exp_id ? c1 : c0;
    ea = exp_id ? a1 : a0;
    eb = exp_id ? b1 : b0;
    exp_data = alu_ref(ec, ea, eb);
    exp_lat  = 1 + ((ec == 3'b010) ? MUL_C : OTHER_C);
    exp_rdy  = exp_id ? 2'b10 : 2'b01;

    @(negedge clk);
    checks++;
    if ({req1_ready, req0_ready} !== exp_rdy) begin
      failures++;
      $display("FAIL %s grant: got ready=%b want %b", tag, {req1_ready, req0_ready}, exp_rdy);
    end
    model_last = exp_id;

    // Inputs change after the grant; none of it may affect the operation in flight.
    @(posedge clk); #1;
    scramble_inputs();
    lat = 0;
    busy_rdy = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (req0_ready || req1_ready) busy_rdy = 1'b1;
      if (resp_valid || lat >= 40) break;
    end
    checks++;
    if (lat != exp_lat || !resp_valid) begin
      failures++;
      $display("FAIL %s latency: got %0d valid=%b want %0d", tag, lat, resp_valid, exp_lat);
    end
    checks++;
    if (resp_id !== 1'(exp_id)) begin
      failures++;
      $display("FAIL %s resp_id: got %0d want %0d", tag, resp_id, exp_id);
    end
    checks++;
    if (resp_data !== exp_data) begin
      failures++;
      $display("FAIL %s resp_data: got %08h want %08h", tag, resp_data, exp_data);
    end
    checks++;
    if (alu_ctrl !== ec || alu_data1 !== ea || alu_data2 !== eb) begin
      failures++;
      $display("FAIL %s alu_regs: got %0h/%08h/%08h want %0h/%08h/%08h", tag,
               alu_ctrl, alu_data1, alu_data2, ec, ea, eb);
    end

    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      scramble_inputs();
      @(negedge clk);
      if (req0_ready || req1_ready) busy_rdy = 1'b1;
      if (resp_valid !== 1'b1 || resp_id !== 1'(exp_id) || resp_data !== exp_data)
        unstable = 1'b1;
    end
    checks++;
    if (unstable) begin
      failures++;
      $display("FAIL %s hold_stable: got valid=%b id=%0d data=%08h want 1/%0d/%08h", tag,
               resp_valid, resp_id, resp_data, exp_id, exp_data);
    end

    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    if (req0_ready || req1_ready) busy_rdy = 1'b1;
    checks++;
    if (resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s handshake_valid: got %b want 1", tag, resp_valid);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (busy_rdy) begin
      failures++;
      $display("FAIL %s busy_ready: got ready while busy want none", tag);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s resp_drop: got %b want 0", tag, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    scramble_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_resp: got %b/%b/%08h want 0/0/0", resp_valid, resp_id, resp_data);
    end
    checks++;
    if (alu_data1 !== 32'd0 || alu_data2 !== 32'd0 || alu_ctrl !== 3'b000) begin
      failures++;
      $display("FAIL reset_alu: got %08h/%08h/%0h want 0/0/0", alu_data1, alu_data2, alu_ctrl);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1;
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 3'b001, 32'd9, 32'd4, 3'b110, 32'hF0, 32'h0F, 0, "alternate");
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_add();
    run_txn(1'b1, 1'b0, 3'b000, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 0, "add");
    req0_valid = 1'b0;
  endtask

  task automatic test_mul();
    run_txn(1'b0, 1'b1, 3'b000, 32'd0, 32'd0, 3'b010, 32'd6, 32'd7, 0, "mul");
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 1'b1, 3'b111, 32'hFF00FF00, 32'h0FF00FF0, 3'b000, 32'd1, 32'd2, 5,
            "backpressure");
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_passthrough();
    run_txn(1'b1, 1'b0, 3'b011, 32'h1234, 32'hABCD, 3'b000, 32'd0, 32'd0, 1, "passthru");
    req0_valid = 1'b0;
  endtask

  task automatic test_reset_mid_exec();
    logic seen;
    req0_valid = 1'b0; req1_valid = 1'b1;
    req1_ctrl = 3'b010; req1_data1 = 32'd6; req1_data2 = 32'd7;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstexec_grant: got %b%b want 10", req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstexec_ready: got %b%b want 00", req1_ready, req0_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'd0 ||
        alu_data1 !== 32'd0 || alu_data2 !== 32'd0 || alu_ctrl !== 3'b000) begin
      failures++;
      $display("FAIL rstexec_values: got %b/%b/%08h/%08h/%08h/%0h want all zero",
               resp_valid, resp_id, resp_data, alu_data1, alu_data2, alu_ctrl);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rstexec_noresp: got resp_valid=1 want 0");
    end
    @(posedge clk); #1;
    run_txn(1'b1, 1'b1, 3'b000, 32'd3, 32'd4, 3'b010, 32'd6, 32'd7, 0, "rstexec_next");
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] v;
    for (int i = 0; i < 30; i++) begin
      v = 2'($urandom_range(1, 3));
      run_txn(v[0], v[1], 3'($urandom), $urandom, $urandom,
              3'($urandom), $urandom, $urandom, $urandom_range(0, 3), "random");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b0;
    req0_data1 = 32'd0; req0_data2 = 32'd0; req0_ctrl = 3'b000;
    req1_data1 = 32'd0; req1_data2 = 32'd0; req1_ctrl = 3'b000;
    test_reset();
    test_alternate();
    test_add();
    test_mul();
    test_backpressure();
    test_passthrough();
    test_reset_mid_exec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
